// File: rtl/payload_char_streamer.sv
//==============================================================================
// Module      : payload_char_streamer
// Description : Frames one payload per transaction onto the shared matcher bus
//               (sod / en / char_q / cls), flushes with null beats, then holds
//               done until the collector acknowledges.
//               Optional byte-depth limit: define PE_DEPTH_LIMIT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module payload_char_streamer #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_DEPTH    = 1460
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic        sod,
   output logic        en,
   output logic [7:0]  char_q,
   output logic [31:0] cls,
   output logic        done,
   input  logic        done_ack
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SOD    = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_flush_cnt;
   logic [3:0]  w_flush_nxt;
   logic        r_first;
   logic        w_first_nxt;
   logic        r_ready;
   logic        r_sod;
   logic        r_en;
   logic        w_en_nxt;
   logic        r_done;
   logic [7:0]  r_char;
   logic [7:0]  w_char_nxt;
   logic [31:0] r_cls;
   logic [31:0] w_cls_nxt;

   logic        w_accept;
   logic        w_deliver;
   logic [25:0] w_letter;
   logic        w_space;
   logic        w_digit;
   logic        w_word;
   logic        w_not_eol;
   logic [31:0] w_cls_dec;

   assign w_accept = s_valid & r_ready;

   // Character-class decode of the incoming byte
   for (genvar k = 0; k < 26; k++) begin : g_letter
      localparam logic [7:0] c_upper = 8'(65 + k);
      localparam logic [7:0] c_lower = 8'(97 + k);
      assign w_letter[k] = (s_data == c_upper) || (s_data == c_lower);
   end

   assign w_space   = ((s_data >= 8'h09) && (s_data <= 8'h0D)) || (s_data == 8'h20);
   assign w_digit   = (s_data >= 8'h30) && (s_data <= 8'h39);
   assign w_word    = (|w_letter) || w_digit || (s_data == 8'h5F);
   assign w_not_eol = (s_data != 8'h0A) && (s_data != 8'h0D);
   assign w_cls_dec = {w_letter, 1'b1, w_word, w_not_eol, w_digit, w_space, r_first};

`ifdef PE_DEPTH_LIMIT_EN
   localparam logic [15:0] c_max_depth = 16'(MAX_DEPTH);

   logic [15:0] r_byte_cnt;

   assign w_deliver = (r_byte_cnt < c_max_depth);

   // Saturates at the limit, so overflow bytes are swallowed without wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
      end else if (w_state_nxt == SOD) begin
         r_byte_cnt <= '0;
      end else if (w_accept && w_deliver) begin
         r_byte_cnt <= r_byte_cnt + 16'd1;
      end
   end
`else
   // Unlimited build: every accepted byte is delivered for any legal MAX_DEPTH
   assign w_deliver = (MAX_DEPTH > 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_flush_cnt <= '0;
         r_first     <= 1'b0;
         r_ready     <= 1'b0;
         r_sod       <= 1'b0;
         r_en        <= 1'b0;
         r_done      <= 1'b0;
         r_char      <= '0;
         r_cls       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_first     <= w_first_nxt;
         r_ready     <= (w_state_nxt == STREAM);
         r_sod       <= (w_state_nxt == SOD);
         r_done      <= (w_state_nxt == DONE);
         r_en        <= w_en_nxt;
         r_char      <= w_char_nxt;
         r_cls       <= w_cls_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flush_nxt = r_flush_cnt;
      w_first_nxt = r_first;
      w_en_nxt    = 1'b0;
      w_char_nxt  = r_char;
      w_cls_nxt   = r_cls;

      case (r_state)
         IDLE: begin
            if (s_valid) begin
               w_state_nxt = SOD;
               w_first_nxt = 1'b1;
            end
         end
         SOD: begin
            w_state_nxt = STREAM;
         end
         STREAM: begin
            if (w_accept) begin
               w_first_nxt = 1'b0;
               if (w_deliver) begin
                  w_en_nxt   = 1'b1;
                  w_char_nxt = s_data;
                  w_cls_nxt  = w_cls_dec;
               end
               if (s_last) begin
                  w_state_nxt = FLUSH;
                  w_flush_nxt = c_flush_init;
               end
            end
         end
         FLUSH: begin
            // Null beats let sticky end states capture matches on the last byte
            w_char_nxt = '0;
            w_cls_nxt  = '0;
            if (r_flush_cnt != 4'd0) begin
               w_en_nxt    = 1'b1;
               w_flush_nxt = r_flush_cnt - 4'd1;
            end else begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (done_ack) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign s_ready = r_ready;
   assign sod     = r_sod;
   assign en      = r_en;
   assign char_q  = r_char;
   assign cls     = r_cls;
   assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_payload_char_streamer.sv
//==============================================================================
// Module      : tb_payload_char_streamer
// Description : Scoreboard bench for payload_char_streamer; stimulus pushes
//               expected beats, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_payload_char_streamer;

   localparam int c_flush     = 2;
   localparam int c_max_depth = 3;
`ifdef PE_DEPTH_LIMIT_EN
   localparam bit c_limit_en = 1'b1;
`else
   localparam bit c_limit_en = 1'b0;
`endif

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic [7:0]  s_data   = 8'h00;
   logic        s_valid  = 1'b0;
   logic        s_last   = 1'b0;
   logic        done_ack = 1'b0;
   logic        s_ready;
   logic        sod;
   logic        en;
   logic [7:0]  char_q;
   logic [31:0] cls;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [39:0] sb [$];
   logic [39:0] m_exp;
   logic [7:0]  prev_char = 8'h00;
   logic [31:0] prev_cls  = 32'h0;

   logic [7:0]  pl_data [0:7];
   logic [31:0] pl_cls  [0:7];

   payload_char_streamer #(
      .FLUSH_CYCLES (c_flush),
      .MAX_DEPTH    (c_max_depth)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .sod      (sod),
      .en       (en),
      .char_q   (char_q),
      .cls      (cls),
      .done     (done),
      .done_ack (done_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every en beat must match the head of the scoreboard; gap cycles hold
   always @(negedge clk) begin
      if (en) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: actual char=%0h cls=%0h required=no beat", char_q, cls);
         end else begin
            m_exp = sb.pop_front();
            chk("beat_char", 64'(char_q), 64'(m_exp[39:32]));
            chk("beat_cls", 64'(cls), 64'(m_exp[31:0]));
         end
      end else if (s_ready) begin
         chk("gap_cls_hold", 64'(cls), 64'(prev_cls));
         chk("gap_char_hold", 64'(char_q), 64'(prev_char));
      end
      prev_char = char_q;
      prev_cls  = cls;
   end

   task automatic set_byte(input int i, input logic [7:0] d, input logic [31:0] c);
      pl_data[i] = d;
      pl_cls[i]  = c;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
      chk({tag, "_sod"}, 64'(sod), 64'(0));
      chk({tag, "_en"}, 64'(en), 64'(0));
      chk({tag, "_char_q"}, 64'(char_q), 64'(0));
      chk({tag, "_cls"}, 64'(cls), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
   endtask

   // Drives one payload from IDLE through to done; leaves done asserted
   task automatic run_payload(input string tag, input int n, input bit toggle, input bit probe_ack);
      int idx;
      int waitc;
      bit acc;
      idx     = 0;
      s_data  = pl_data[0];
      s_last  = (n == 1);
      s_valid = 1'b1;
      waitc   = 0;
      do begin
         @(posedge clk); #1;
         waitc++;
      end while (!sod && waitc < 20);
      chk({tag, "_sod_latency"}, 64'(waitc), 64'(1));
      chk({tag, "_sod_en"}, 64'(en), 64'(0));
      chk({tag, "_sod_ready"}, 64'(s_ready), 64'(0));
      waitc = 0;
      while (idx < n && waitc < 200) begin
         acc = s_valid & s_ready;
         if (acc && (!c_limit_en || idx < c_max_depth))
            sb.push_back({pl_data[idx], pl_cls[idx]});
         if (acc && idx == n - 1)
            for (int j = 0; j < c_flush; j++) sb.push_back(40'h0);
         done_ack = probe_ack & ~s_valid;
         @(posedge clk); #1;
         waitc++;
         if (acc) begin
            idx++;
            if (idx < n) begin
               s_data  = pl_data[idx];
               s_last  = (idx == n - 1);
               s_valid = toggle ? 1'b0 : 1'b1;
            end else begin
               s_valid = 1'b0;
               s_last  = 1'b0;
            end
         end else if (toggle) begin
            s_valid = 1'b1;
         end
      end
      done_ack = 1'b0;
      chk({tag, "_all_accepted"}, 64'(idx), 64'(n));
      waitc = 0;
      while (!done && waitc < 40) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk({tag, "_done_latency"}, 64'(waitc), 64'(c_flush + 1));
      chk({tag, "_done_ready"}, 64'(s_ready), 64'(0));
      chk({tag, "_sb_drained"}, 64'(sb.size()), 64'(0));
   endtask

   task automatic ack_done(input string tag);
      done_ack = 1'b1;
      @(posedge clk); #1;
      done_ack = 1'b0;
      chk({tag, "_ack_done_low"}, 64'(done), 64'(0));
      chk({tag, "_ack_idle_ready"}, 64'(s_ready), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // "R1\n" back-to-back
      set_byte(0, 8'h52, 32'h0080_0039);
      set_byte(1, 8'h31, 32'h0000_003C);
      set_byte(2, 8'h0A, 32'h0000_0022);
      run_payload("r1nl", 3, 1'b0, 1'b0);
      ack_done("r1nl");

      // single space byte
      set_byte(0, 8'h20, 32'h0000_002B);
      run_payload("single", 1, 1'b0, 1'b0);
      ack_done("single");

      // "a_9\r" with valid toggling; done_ack pulsed in gaps must be ignored
      set_byte(0, 8'h61, 32'h0000_0079);
      set_byte(1, 8'h5F, 32'h0000_0038);
      set_byte(2, 8'h39, 32'h0000_003C);
      set_byte(3, 8'h0D, 32'h0000_0022);
      run_payload("toggle", 4, 1'b1, 1'b1);

      // done held without acknowledge
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_done", 64'(done), 64'(1));
         chk("hold_ready", 64'(s_ready), 64'(0));
      end

      // acknowledge with s_valid already high: IDLE, then sod
      done_ack = 1'b1;
      s_valid  = 1'b1;
      s_data   = 8'h5A;
      s_last   = 1'b0;
      @(posedge clk); #1;
      done_ack = 1'b0;
      chk("ack_gap_done", 64'(done), 64'(0));
      chk("ack_gap_sod0", 64'(sod), 64'(0));
      @(posedge clk); #1;
      chk("ack_gap_sod1", 64'(sod), 64'(1));

      // reset while the second byte is on the bus
      sb.push_back({8'h5A, 32'h8000_0039});
      @(posedge clk); #1;
      chk("rst_pre_ready", 64'(s_ready), 64'(1));
      @(posedge clk); #1;
      s_data = 8'h7A;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      chk("midrst_sb", 64'(sb.size()), 64'(0));
      s_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_idle_ready", 64'(s_ready), 64'(0));
      chk("post_rst_idle_sod", 64'(sod), 64'(0));

      // "Zz" after reset: fresh sod and start anchor
      set_byte(0, 8'h5A, 32'h8000_0039);
      set_byte(1, 8'h7A, 32'h8000_0038);
      run_payload("post_rst", 2, 1'b0, 1'b0);
      ack_done("post_rst");

      // "abcde": fully delivered, or first three only when the depth limit is built in
      set_byte(0, 8'h61, 32'h0000_0079);
      set_byte(1, 8'h62, 32'h0000_00B8);
      set_byte(2, 8'h63, 32'h0000_0138);
      set_byte(3, 8'h64, 32'h0000_0238);
      set_byte(4, 8'h65, 32'h0000_0438);
      run_payload("depth", 5, 1'b0, 1'b0);
      ack_done("depth");

      repeat (3) @(posedge clk);
      #1;
      chk("final_sb_empty", 64'(sb.size()), 64'(0));
      chk("final_idle_en", 64'(en), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/payload_char_streamer.md
# payload_char_streamer

Front end of the payload engine array: accepts one payload byte per cycle over a valid/ready stream and drives the shared matcher bus (`sod`, `en`, registered character-class lines, registered byte) that every generated regex engine consumes. It frames each payload: a one-cycle `sod` clear before the first byte, one `en` beat per byte, then a null-character flush so sticky end states capture late matches. It then signals `done` so the match collector samples engine outputs.

## Interface
- `FLUSH_CYCLES`, 2: null beats (`en`=1, classes 0) issued after the last byte; legal range 1..15.
- `MAX_DEPTH`, 1460: byte limit per payload; only used when `PE_DEPTH_LIMIT_EN` is defined; legal range 1..65535.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_data` in 8: payload byte.
- `s_valid` in 1: byte present.
- `s_last` in 1: byte is the final byte of the payload.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `sod` out 1: start-of-data clear to the engines, registered, glitch-free.
- `en` out 1: engine clock enable, registered.
- `char_q` out 8: registered byte for literal decoders.
- `cls` out 32: registered class lines.
  - [0] start anchor: first byte of the payload.
  - [1] `\s`: 0x09–0x0D, 0x20.
  - [2] `\d`.
  - [3] `[^\r\n]`.
  - [4] `\w`.
  - [5] any byte.
  - [6+k] letter k, case-insensitive, k=0..25.
- `done` out 1: flush complete; held until acknowledged.
- `done_ack` in 1: collector has sampled the engine outputs.

## Operation
- FSM states: IDLE, SOD, STREAM, FLUSH, DONE.
- IDLE:
  - `s_ready`=0.
  - When `s_valid`=1, go to SOD.
- SOD:
  - Exactly one cycle; registered `sod`=1 during it, `en`=0.
  - Go to STREAM.
- STREAM:
  - `s_ready`=1.
  - Each accepted byte produces `en`=1, `char_q`=byte and decoded `cls` on the next cycle.
  - When no byte is accepted, `en`=0 and `cls`/`char_q` are held.
  - `cls[0]`=1 only on the beat of the first byte after SOD.
  - An accepted byte with `s_last`=1 goes to FLUSH and loads the flush counter with `FLUSH_CYCLES`.
- FLUSH:
  - `s_ready`=0.
  - Each cycle drives `en`=1, `cls`=0, `char_q`=0x00, and decrements the counter.
  - At 0, go to DONE.
- DONE:
  - `done`=1, `en`=0.
  - `done_ack`=1 returns the FSM to IDLE next cycle with `done`=0.
  - `done_ack` outside DONE is ignored.
- Single-byte payload (`s_last` on the first byte): that beat carries `cls[0]`=1, then FLUSH. Empty payloads do not exist.
- Reset, including mid-payload:
  - FSM goes to IDLE; the byte counter and flush counter clear.
  - All outputs are 0: `s_ready`, `sod`, `en`, `char_q`, `cls`, `done`.
  - Engine clearing on reset is the top level's job: it ORs `rst` into the engine clear. This block does not pulse `sod` on reset.

## Timing
- Byte accepted in cycle t → `en`/`cls`/`char_q` valid in cycle t+1.
- `sod` is high in the cycle before the first byte can be accepted; the first `en` is at least 2 cycles after `sod` rises.
- Last byte accepted at t:
  - Flush beats occupy t+2 .. t+1+`FLUSH_CYCLES`.
  - `done` rises at t+2+`FLUSH_CYCLES`.
- Minimum inter-payload gap from `done_ack` to the next `sod`: 2 cycles (IDLE, then SOD).
- Back-to-back bytes with `s_valid` held high sustain one `en` beat per cycle.

## Configuration
- `PE_DEPTH_LIMIT_EN` defined:
  - A 16-bit byte counter counts accepted bytes.
  - Bytes beyond `MAX_DEPTH` are still accepted (`s_ready`=1) but produce `en`=0 and no `cls`/`char_q` update.
  - `s_last` still triggers FLUSH.
  - The counter saturates at `MAX_DEPTH`.
- `PE_DEPTH_LIMIT_EN` undefined:
  - No counter and no limit; every accepted byte is delivered.

## Test plan
- Payload "R1\n", no stalls:
  - `sod` pulse, then 3 `en` beats.
  - Beat 1: `cls[0]`, `cls[5]`, `cls[6+17]`, `cls[3]`, `cls[4]`.
  - Beat 2: `cls[2]`, `cls[3]`, `cls[4]`.
  - Beat 3: `cls[1]` only plus `cls[5]`.
  - Then 2 null beats; `done` at t+4.
- Single byte 0x20 with `s_last` → one beat with `cls[0]`, `cls[1]`, `cls[3]`, `cls[5]`; FLUSH; `done`.
- `s_valid` toggling every other cycle over 4 bytes → exactly 4 `en` beats; `cls` held in gap cycles; no `cls[0]` after beat 1.
- Assert `rst` during STREAM byte 2 → next cycle all outputs 0 and FSM in IDLE; the next payload starts with a fresh `sod`.
- `done_ack` held low for 10 cycles → `done` stays 1 and `s_ready` stays 0; `done_ack` pulse → IDLE, then `sod` 2 cycles later if `s_valid`.
- With `PE_DEPTH_LIMIT_EN` and `MAX_DEPTH`=3, a 5-byte payload → all 5 bytes accepted, 3 `en` data beats, `FLUSH_CYCLES` null beats, then `done`.
